pattern_serializer: RTL and testbench
=====================================

# pattern_serializer

Upstream stimulus stage for the serial sequence detector. Loads a parallel bit pattern of 1–16 bits and shifts it out MSB-first on `z` at a programmable bit rate, once or repeatedly. It also produces `max_tick_reg`, a one-cycle pulse marking the end of each counting window of `WINDOW` bits. The detector uses that pulse to clear its match count. Both outputs connect directly to the detector's `z` and `max_tick_reg` inputs.

## Interface
- `DIV_WIDTH`, default 8: width of the bit-period divider.
- `WINDOW`, default 64: number of emitted bits per counting window. Legal range is 2..65535.
- `clk` input 1: sole clock; all state updates on its rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `load` input 1: start request; samples `pattern`, `len`, `div`.
- `stop` input 1: abort shifting and return to IDLE.
- `repeat_en` input 1: replay the pattern when it is exhausted; sampled at each wrap.
- `pattern` input 16: pattern bits; bit `len-1` is sent first.
- `len` input 5: pattern length, legal range 1..16. A value of 0 or greater than 16 causes the load to be ignored.
- `div` input DIV_WIDTH: bit period is `div+1` clocks.
- `z` output 1: serial data to the detector.
- `bit_valid` output 1: one-cycle pulse in the first cycle of each new bit on `z`.
- `busy` output 1: high in SHIFT.
- `max_tick_reg` output 1: one-cycle window-end pulse.

## Operation
- **Reset values** (asynchronous, while `reset`=0):
  - state IDLE
  - `z`=0, `bit_valid`=0, `busy`=0, `max_tick_reg`=0
  - divider, bit index and window counter all 0
- **Registers:** `shreg`[15:0], `idx`[3:0], `div_q`, `divcnt`[DIV_WIDTH-1:0], `wcnt`[15:0].
- **IDLE:**
  - `z` is held at 0.
  - `load` with a legal `len` latches `pattern`, `div`, and `idx`=`len-1`.
  - It also clears `divcnt` and `wcnt`, and enters SHIFT.
  - On that same edge it sets `z`=`pattern[len-1]` and `bit_valid`=1.
- **SHIFT:**
  - `divcnt` increments each clock.
  - A tick occurs in the cycle where `divcnt`==`div_q`; `divcnt` then returns to 0.
  - With `div`=0 a tick occurs every cycle.
- **On a tick:**
  - `wcnt` increments, since one bit has completed.
  - If `wcnt` was `WINDOW-1`, `max_tick_reg`=1 on the next cycle and `wcnt` returns to 0.
  - If `idx`>0: `idx` decrements, `z`=`shreg[idx-1]`, `bit_valid`=1.
  - If `idx`==0 and `repeat_en`=1: `idx`=`len_q-1`, `z`=`shreg[len_q-1]`, `bit_valid`=1.
  - If `idx`==0 and `repeat_en`=0: go to IDLE with `z`=0. The window counter is retained until the next load.
- **`load` in SHIFT:** restarts exactly as a load from IDLE. `load` has priority over a coincident tick, and no `max_tick_reg` is produced by that tick.
- **`stop`:**
  - In any state, the next state is IDLE with `z`=0.
  - `stop` has priority over `load`.
  - A window pulse due on the same tick is still emitted.
- **Width rules:** `divcnt` compares equal only, with no wrap beyond `div_q`. `wcnt` is 16-bit and never exceeds `WINDOW-1`.
- **Downstream note:** the detector samples `z` every clock, so each bit must appear exactly once. Systems driving it directly use `div`=0; other `div` values are intended for gated/enable-based consumers.

## Timing
- **Load latency:** `load` sampled at edge k gives the first bit on `z` from cycle k+1.
- **Bit n** (n=0 first) occupies cycles k+1+n(`div`+1) through k+(n+1)(`div`+1).
- **`bit_valid`:** high only in the first cycle of each bit.
- **`max_tick_reg`:** high for exactly one cycle. That cycle coincides with the first cycle of bit number `WINDOW` counted from the load, or with the first cycle after a window-completing final bit that returns to IDLE.
- **`busy`:** rises at k+1. It falls on the cycle after the last bit's period ends, or on the cycle after `stop`.
- **Reset mid-operation:** all outputs go low immediately, independent of `clk`. Operation resumes in IDLE at the first edge after `reset` deasserts.

## Test plan
- **Single pass, `div`=0:** reset low then high; `load` with `pattern`=0x0578, `len`=11, `repeat_en`=0 → `z`=1,0,1,0,1,1,1,1,0,0,0 on cycles k+1..k+11; `busy` low from k+12; detector count = 1.
- **Repeat + window, `div`=0:** same pattern with `repeat_en`=1 and `WINDOW`=22 → pattern repeats seamlessly; `max_tick_reg` pulses at k+23 and k+45 only.
- **Divider:** `div`=3, `pattern`=0x0005, `len`=3 → `z`=1 for cycles 1–4, 0 for 5–8, 1 for 9–12; `bit_valid` only at 1, 5, 9.
- **Illegal length and restart:** `len`=0 in IDLE → no state change. Then `load` mid-stream in SHIFT coincident with a tick → new pattern's MSB appears next cycle; `wcnt` restarts; no `max_tick_reg` pulse.
- **Stop/load priority:** `stop`=1 and `load`=1 together during SHIFT → IDLE, `z`=0, `busy`=0 next cycle.
- **Async reset:** assert `reset`=0 mid-bit between clock edges → `z`, `busy`, `max_tick_reg` drop at once; after release, outputs stay 0 until a new `load`.

Source files
------------

// File: rtl/pattern_serializer.sv
// Parallel-to-serial pattern source for the sequence detector: shifts a 1..16 bit
// pattern MSB-first on z at a programmable bit period and marks counting windows.
module pattern_serializer #(
    parameter int DIV_WIDTH = 8,
    parameter int WINDOW    = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic                 stop,
    input  logic                 repeat_en,
    input  logic [15:0]          pattern,
    input  logic [4:0]           len,
    input  logic [DIV_WIDTH-1:0] div,
    output logic                 z,
    output logic                 bit_valid,
    output logic                 busy,
    output logic                 max_tick_reg
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    localparam logic [15:0]          WCNT_LAST = 16'(WINDOW - 1);
    localparam logic [DIV_WIDTH-1:0] DIV_ONE   = DIV_WIDTH'(1);

    state_e               state_q, state_d;
    logic [15:0]          shreg_q, shreg_d;
    logic [3:0]           idx_q, idx_d;
    logic [3:0]           lenm1_q, lenm1_d;
    logic [DIV_WIDTH-1:0] div_q, div_d;
    logic [DIV_WIDTH-1:0] divcnt_q, divcnt_d;
    logic [15:0]          wcnt_q, wcnt_d;
    logic                 z_q, z_d;
    logic                 bit_valid_q, bit_valid_d;
    logic                 busy_q, busy_d;
    logic                 max_tick_q, max_tick_d;

    logic                 load_ok_s;
    logic [3:0]           len_m1_s;
    logic                 tick_s;
    logic                 win_end_s;
    logic [15:0]          wcnt_inc_s;

    assign load_ok_s  = load && (len != 5'd0) && (len <= 5'd16);
    assign len_m1_s   = len[3:0] - 4'd1;    // len=16 wraps to index 15
    assign tick_s     = (state_q == ST_SHIFT) && (divcnt_q == div_q);
    assign win_end_s  = tick_s && (wcnt_q == WCNT_LAST);
    assign wcnt_inc_s = win_end_s ? 16'd0 : (wcnt_q + 16'd1);

    // Next-state and output decode; stop beats load, load beats a coincident tick.
    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        idx_d       = idx_q;
        lenm1_d     = lenm1_q;
        div_d       = div_q;
        divcnt_d    = divcnt_q;
        wcnt_d      = wcnt_q;
        z_d         = z_q;
        bit_valid_d = 1'b0;
        max_tick_d  = 1'b0;

        if (stop) begin
            state_d  = ST_IDLE;
            z_d      = 1'b0;
            divcnt_d = '0;
            if (tick_s) begin
                wcnt_d     = wcnt_inc_s;
                max_tick_d = win_end_s;
            end else begin
                wcnt_d = wcnt_q;
            end
        end else if (load_ok_s) begin
            state_d     = ST_SHIFT;
            shreg_d     = pattern;
            idx_d       = len_m1_s;
            lenm1_d     = len_m1_s;
            div_d       = div;
            divcnt_d    = '0;
            wcnt_d      = 16'd0;
            z_d         = pattern[len_m1_s];
            bit_valid_d = 1'b1;
        end else if (state_q == ST_SHIFT) begin
            if (tick_s) begin
                divcnt_d   = '0;
                wcnt_d     = wcnt_inc_s;
                max_tick_d = win_end_s;
                if (idx_q != 4'd0) begin
                    idx_d       = idx_q - 4'd1;
                    z_d         = shreg_q[idx_q - 4'd1];
                    bit_valid_d = 1'b1;
                end else if (repeat_en) begin
                    idx_d       = lenm1_q;
                    z_d         = shreg_q[lenm1_q];
                    bit_valid_d = 1'b1;
                end else begin
                    // wcnt is kept; only the next load clears it
                    state_d = ST_IDLE;
                    z_d     = 1'b0;
                end
            end else begin
                divcnt_d = divcnt_q + DIV_ONE;
            end
        end else begin
            z_d = 1'b0;
        end

        busy_d = (state_d == ST_SHIFT);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            shreg_q     <= 16'd0;
            idx_q       <= 4'd0;
            lenm1_q     <= 4'd0;
            div_q       <= '0;
            divcnt_q    <= '0;
            wcnt_q      <= 16'd0;
            z_q         <= 1'b0;
            bit_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            max_tick_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            idx_q       <= idx_d;
            lenm1_q     <= lenm1_d;
            div_q       <= div_d;
            divcnt_q    <= divcnt_d;
            wcnt_q      <= wcnt_d;
            z_q         <= z_d;
            bit_valid_q <= bit_valid_d;
            busy_q      <= busy_d;
            max_tick_q  <= max_tick_d;
        end
    end

    assign z            = z_q;
    assign bit_valid    = bit_valid_q;
    assign busy         = busy_q;
    assign max_tick_reg = max_tick_q;

endmodule

// File: tb/tb_pattern_serializer.sv
// Scoreboard bench for pattern_serializer: expected bit/window events are queued at
// load time from the stream rules; a negedge monitor pops them as the DUT emits.
module tb_pattern_serializer;

    localparam int W = 22;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load = 1'b0;
    logic        stop = 1'b0;
    logic        repeat_en = 1'b0;
    logic [15:0] pattern = 16'd0;
    logic [4:0]  len = 5'd0;
    logic [7:0]  div = 8'd0;
    logic        z, bit_valid, busy, max_tick_reg;

    int cyc = 0;
    int errors = 0;
    int checks = 0;

    typedef struct {
        int   c;
        logic b;
    } bit_t;

    bit_t bq[$];
    int   mq[$];
    bit_t mon_e;
    logic last_z = 1'b0;

    pattern_serializer #(.DIV_WIDTH(8), .WINDOW(W)) dut (
        .clk(clk), .reset(rst_n), .load(load), .stop(stop), .repeat_en(repeat_en),
        .pattern(pattern), .len(len), .div(div),
        .z(z), .bit_valid(bit_valid), .busy(busy), .max_tick_reg(max_tick_reg)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every bit_valid pulse and window pulse must match the next queued event.
    always @(negedge clk) begin
        if (bit_valid === 1'b1) begin
            if (bq.size() == 0) begin
                chk("unexpected_bit", 32'd1, 32'd0);
            end else begin
                mon_e = bq.pop_front();
                chk("bit_cycle", cyc, mon_e.c);
                chk("bit_z", {31'd0, z}, {31'd0, mon_e.b});
            end
            last_z = z;
        end else if (busy === 1'b1) begin
            chk("hold_z", {31'd0, z}, {31'd0, last_z});
        end else begin
            chk("idle_z", {31'd0, z}, 32'd0);
        end
        if (max_tick_reg === 1'b1) begin
            if (mq.size() == 0) chk("unexpected_max_tick", 32'd1, 32'd0);
            else chk("max_tick_cycle", cyc, mq.pop_front());
        end
    end

    // Caller is at a negedge; returns the cycle in which the first bit is visible.
    task automatic do_load(input logic [15:0] p, input logic [4:0] l, input logic [7:0] d,
                           input logic r, output int e);
        pattern = p; len = l; div = d; repeat_en = r; load = 1'b1;
        @(posedge clk);
        #1;
        e = cyc;
        load = 1'b0;
    endtask

    // Bit n is visible from cycle e+n*pp; a window pulse follows every W-th completed bit.
    task automatic expect_stream(input int e, input logic [15:0] p, input int l, input int pp,
                                 input int nbits, input int cutoff);
        int   c;
        bit_t t;
        for (int n = 0; n < nbits; n++) begin
            c = e + n * pp;
            if (c < cutoff) begin
                t.c = c;
                t.b = p[l - 1 - (n % l)];
                bq.push_back(t);
            end
        end
        for (int m = 1; W * m <= nbits; m++) begin
            c = e + W * m * pp;
            if (c < cutoff) mq.push_back(c);
        end
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (busy === 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("busy_falls", {31'd0, busy}, 32'd0);
        repeat (2) @(negedge clk);
        chk("bits_drained", bq.size(), 32'd0);
        chk("ticks_drained", mq.size(), 32'd0);
    endtask

    // passes==1 is a single shot; otherwise repeat_en drops during the last pass.
    task automatic run(input logic [15:0] p, input logic [4:0] l, input logic [7:0] d,
                       input int passes);
        int e, pp, li;
        pp = int'(d) + 1;
        li = int'(l);
        @(negedge clk);
        do_load(p, l, d, passes > 1, e);
        chk("busy_rises", {31'd0, busy}, 32'd1);
        expect_stream(e, p, li, pp, passes * li, 32'h3fff_ffff);
        if (passes > 1) begin
            while (cyc < e + (passes - 1) * li * pp) @(negedge clk);
            repeat_en = 1'b0;
        end
        wait_idle(passes * li * pp + 10);
    endtask

    initial begin
        int e, ea, eb;
        logic [15:0] rp;
        logic [4:0]  rl;
        logic [7:0]  rd;
        int          rn;

        repeat (3) @(negedge clk);
        chk("rst_z", {31'd0, z}, 32'd0);
        chk("rst_bit_valid", {31'd0, bit_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_max_tick", {31'd0, max_tick_reg}, 32'd0);
        rst_n = 1'b1;

        run(16'h0578, 5'd11, 8'd0, 1);
        run(16'h0578, 5'd11, 8'd0, 4);
        run(16'h0005, 5'd3, 8'd3, 1);

        // Illegal lengths leave the block idle
        @(negedge clk);
        do_load(16'hFFFF, 5'd0, 8'd0, 1'b0, e);
        repeat (3) @(negedge clk);
        chk("len0_busy", {31'd0, busy}, 32'd0);
        do_load(16'hFFFF, 5'd17, 8'd0, 1'b0, e);
        repeat (3) @(negedge clk);
        chk("len17_busy", {31'd0, busy}, 32'd0);

        // Reload exactly on the window-completing tick: no pulse, counter restarts
        do_load(16'h001B, 5'd5, 8'd1, 1'b1, ea);
        expect_stream(ea, 16'h001B, 5, 2, 200, ea + W * 2);
        while (cyc < ea + W * 2 - 1) @(negedge clk);
        do_load(16'h0578, 5'd11, 8'd0, 1'b1, eb);
        chk("restart_edge", eb, ea + W * 2);
        expect_stream(eb, 16'h0578, 11, 1, 22, 32'h3fff_ffff);
        while (cyc < eb + 11) @(negedge clk);
        repeat_en = 1'b0;
        wait_idle(60);

        // stop together with a legal load mid-bit
        @(negedge clk);
        do_load(16'hA5C3, 5'd16, 8'd2, 1'b1, e);
        expect_stream(e, 16'hA5C3, 16, 3, 200, e + 11);
        while (cyc < e + 10) @(negedge clk);
        stop = 1'b1; load = 1'b1; pattern = 16'h1234; len = 5'd8;
        @(negedge clk);
        chk("stop_busy", {31'd0, busy}, 32'd0);
        chk("stop_z", {31'd0, z}, 32'd0);
        stop = 1'b0; load = 1'b0; repeat_en = 1'b0;
        wait_idle(5);

        // Asynchronous reset between clock edges
        @(negedge clk);
        do_load(16'hBEEF, 5'd16, 8'd1, 1'b1, e);
        expect_stream(e, 16'hBEEF, 16, 2, 200, e + 7);
        while (cyc < e + 6) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_z", {31'd0, z}, 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_bit_valid", {31'd0, bit_valid}, 32'd0);
        chk("arst_max_tick", {31'd0, max_tick_reg}, 32'd0);
        repeat_en = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("post_rst_busy", {31'd0, busy}, 32'd0);
        wait_idle(5);

        for (int i = 0; i < 12; i++) begin
            rp = 16'($urandom);
            rl = 5'($urandom_range(16, 1));
            rd = 8'($urandom_range(3, 0));
            rn = int'($urandom_range(3, 1));
            run(rp, rl, rd, rn);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
